// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction memory port, redirect from execute and the decode handshake.
// The master modport is the fetch stage itself; slave is the memory/execute/decode side.
interface instr_fetch_if;
    logic        o_Req;
    logic [31:0] ov_Addr;
    logic        i_Ack;
    logic [31:0] iv_Rdata;
    logic        i_Redirect;
    logic [31:0] iv_Target;
    logic        o_Valid;
    logic [31:0] ov_Instr;
    logic [31:0] ov_Pc;
    logic        i_Ready;

    modport master (
        output o_Req, ov_Addr, o_Valid, ov_Instr, ov_Pc,
        input  i_Ack, iv_Rdata, i_Redirect, iv_Target, i_Ready
    );

    modport slave (
        input  o_Req, ov_Addr, o_Valid, ov_Instr, ov_Pc,
        output i_Ack, iv_Rdata, i_Redirect, iv_Target, i_Ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding word read, small PC/instruction FIFO toward decode,
// and redirect handling that flushes buffered words and discards a stale in-flight response.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_Enb,
    instr_fetch_if.master bus
);
    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW         = AW + 1;
    localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   pend_q, pend_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   pc_mem_d    [DEPTH];

    logic          head_valid;
    logic          do_pop;
    logic          do_push;
    logic          room;
    logic [31:0]   target;

    assign head_valid = (count_q != '0);
    assign target     = bus.iv_Target & 32'hFFFF_FFFC;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        pend_d      = pend_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        do_pop      = 1'b0;
        do_push     = 1'b0;
        room        = 1'b0;

        if (i_Enb) begin
            if (bus.i_Redirect) begin
                count_d  = '0;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                req_d    = 1'b1;
                // Only a request that is still waiting for its ack forces a drain of the stale word.
                if (state_q == IDLE || bus.i_Ack) begin
                    addr_d  = target;
                    state_d = REQ;
                end else begin
                    pend_d  = target;
                    state_d = DRAIN;
                end
            end else begin
                do_pop  = head_valid && bus.i_Ready;
                do_push = (state_q == REQ) && bus.i_Ack;
                count_d = count_q + CW'(do_push) - CW'(do_pop);
                room    = (count_d < CW'(DEPTH));

                if (do_pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
                if (do_push) begin
                    instr_mem_d[wr_ptr_q] = bus.iv_Rdata;
                    pc_mem_d[wr_ptr_q]    = addr_q;
                    wr_ptr_d              = wr_ptr_q + AW'(1);
                end

                case (state_q)
                    IDLE: begin
                        if (room) begin
                            state_d = REQ;
                            req_d   = 1'b1;
                        end
                    end
                    REQ: begin
                        if (bus.i_Ack) begin
                            addr_d = addr_q + 32'd4;
                            if (!room) begin
                                state_d = IDLE;
                                req_d   = 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (bus.i_Ack) begin
                            addr_d  = pend_q;
                            state_d = REQ;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            addr_q   <= RESET_ADDR;
            pend_q   <= RESET_ADDR;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= NOP;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    assign bus.o_Req    = req_q;
    assign bus.ov_Addr  = addr_q;
    assign bus.o_Valid  = head_valid;
    assign bus.ov_Instr = head_valid ? instr_mem_q[rd_ptr_q] : NOP;
    assign bus.ov_Pc    = head_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based model of the fetch stage.
module tb_instr_fetch;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic clk;
    logic rst;
    logic enb;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC (RPC),
        .DEPTH    (DEPTH)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .i_Enb (enb),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared = 0;
    int nFailed   = 0;

    // Model: is a read outstanding, is its answer stale, the fetch address, the address waiting
    // behind a stale read, and the buffered {pc, instr} words in decode order.
    bit          mReq;
    bit          mStale;
    logic [31:0] mAddr;
    logic [31:0] mPend;
    logic [63:0] mFifo [$];

    function automatic void resetModel();
        mReq   = 1'b0;
        mStale = 1'b0;
        mAddr  = RPC;
        mPend  = RPC;
        mFifo.delete();
    endfunction

    function automatic void modelStep(input bit e, input bit ack, input logic [31:0] rdata,
                                      input bit redir, input logic [31:0] tgt, input bit rdy);
        logic [31:0] t;
        bit          wasReq;
        if (!e) return;
        t = tgt & 32'hFFFF_FFFC;
        if (redir) begin
            mFifo.delete();
            if (!mReq || ack) begin
                mAddr  = t;
                mStale = 1'b0;
            end else begin
                mPend  = t;
                mStale = 1'b1;
            end
            mReq = 1'b1;
            return;
        end
        if (mFifo.size() > 0 && rdy) void'(mFifo.pop_front());
        wasReq = mReq;
        if (wasReq && !mStale && ack) mFifo.push_back({mAddr, rdata});
        if (!wasReq) begin
            if (mFifo.size() < DEPTH) mReq = 1'b1;
        end else if (ack) begin
            if (mStale) begin
                mAddr  = mPend;
                mStale = 1'b0;
            end else begin
                mAddr = mAddr + 32'd4;
                mReq  = (mFifo.size() < DEPTH);
            end
        end
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic [63:0] head;
        head = (mFifo.size() > 0) ? mFifo[0] : {32'h0, NOP};
        checkVal("o_Req",    {31'b0, bus.o_Req},   {31'b0, mReq});
        checkVal("ov_Addr",  bus.ov_Addr,          mAddr);
        checkVal("o_Valid",  {31'b0, bus.o_Valid}, {31'b0, (mFifo.size() > 0)});
        checkVal("ov_Instr", bus.ov_Instr,         head[31:0]);
        checkVal("ov_Pc",    bus.ov_Pc,            head[63:32]);
    endtask

    // Drives one cycle of inputs at the falling edge, advances the model, then checks after the edge.
    task automatic applyStimulus(input bit e, input bit ack, input bit redir,
                                 input logic [31:0] tgt, input bit rdy);
        logic [31:0] rdata;
        rdata          = ack ? (mAddr ^ XMASK) : 32'($urandom);
        enb            = e;
        bus.i_Ack      = ack;
        bus.iv_Rdata   = rdata;
        bus.i_Redirect = redir;
        bus.iv_Target  = tgt;
        bus.i_Ready    = rdy;
        modelStep(e, ack, rdata, redir, tgt, rdy);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        rst            = 1'b1;
        enb            = 1'b1;
        bus.i_Ack      = 1'b0;
        bus.iv_Rdata   = '0;
        bus.i_Redirect = 1'b0;
        bus.iv_Target  = '0;
        bus.i_Ready    = 1'b0;
        resetModel();
        repeat (2) @(negedge clk);
        checkOutput();
        checkVal("rst_req",   {31'b0, bus.o_Req},   32'd0);
        checkVal("rst_addr",  bus.ov_Addr,          32'h0000_0100);
        checkVal("rst_valid", {31'b0, bus.o_Valid}, 32'd0);
        checkVal("rst_instr", bus.ov_Instr,         32'h0000_0013);
        checkVal("rst_pc",    bus.ov_Pc,            32'h0);
        rst = 1'b0;

        applyStimulus(1, 0, 0, 0, 1);
        checkVal("start_req",  {31'b0, bus.o_Req}, 32'd1);
        checkVal("start_addr", bus.ov_Addr,        32'h0000_0100);
        applyStimulus(1, 1, 0, 0, 1);
        checkVal("ack1_pc",    bus.ov_Pc,    32'h0000_0100);
        checkVal("ack1_instr", bus.ov_Instr, 32'hA5A5_0100);
        checkVal("ack1_addr",  bus.ov_Addr,  32'h0000_0104);
        applyStimulus(1, 1, 0, 0, 1);
        checkVal("ack2_pc",    bus.ov_Pc,    32'h0000_0104);
        applyStimulus(1, 1, 0, 0, 1);
        checkVal("ack3_pc",    bus.ov_Pc,    32'h0000_0108);
        checkVal("ack3_addr",  bus.ov_Addr,  32'h0000_010C);

        applyStimulus(1, 1, 0, 0, 0);
        checkVal("full_req",  {31'b0, bus.o_Req}, 32'd0);
        checkVal("full_addr", bus.ov_Addr,        32'h0000_0110);
        checkVal("full_pc",   bus.ov_Pc,          32'h0000_0108);
        applyStimulus(1, 0, 0, 0, 1);
        checkVal("resume_req", {31'b0, bus.o_Req}, 32'd1);
        checkVal("resume_pc",  bus.ov_Pc,          32'h0000_010C);

        applyStimulus(1, 0, 1, 32'h0000_0203, 0);
        checkVal("drain_valid", {31'b0, bus.o_Valid}, 32'd0);
        checkVal("drain_addr",  bus.ov_Addr,          32'h0000_0110);
        applyStimulus(1, 0, 0, 0, 0);
        checkVal("drain_hold",  bus.ov_Addr,          32'h0000_0110);
        applyStimulus(1, 1, 0, 0, 0);
        checkVal("stale_valid", {31'b0, bus.o_Valid}, 32'd0);
        checkVal("stale_addr",  bus.ov_Addr,          32'h0000_0200);
        applyStimulus(1, 1, 0, 0, 0);
        checkVal("tgt_pc",      bus.ov_Pc,            32'h0000_0200);
        checkVal("tgt_instr",   bus.ov_Instr,         32'hA5A5_0200);

        applyStimulus(1, 1, 1, 32'h0000_0040, 0);
        checkVal("redir_ack_valid", {31'b0, bus.o_Valid}, 32'd0);
        checkVal("redir_ack_addr",  bus.ov_Addr,          32'h0000_0040);

        repeat (5) applyStimulus(0, 1, 0, 0, 1);
        checkVal("stall_addr",  bus.ov_Addr,          32'h0000_0040);
        checkVal("stall_valid", {31'b0, bus.o_Valid}, 32'd0);

        applyStimulus(1, 0, 1, 32'hFFFF_FFF8, 1);
        applyStimulus(1, 1, 0, 0, 1);
        checkVal("wrap_addr0", bus.ov_Addr, 32'hFFFF_FFF8);
        applyStimulus(1, 1, 0, 0, 1);
        checkVal("wrap_pc0",   bus.ov_Pc,   32'hFFFF_FFF8);
        applyStimulus(1, 1, 0, 0, 1);
        checkVal("wrap_pc1",   bus.ov_Pc,   32'hFFFF_FFFC);
        checkVal("wrap_addr2", bus.ov_Addr, 32'h0000_0000);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0,
                          32'($urandom), ($urandom % 4) != 0);
        end

        applyStimulus(1, 0, 1, 32'h0000_0300, 0);
        checkVal("pre_rst_req", {31'b0, bus.o_Req}, 32'd1);
        rst = 1'b1;
        resetModel();
        #1;
        checkVal("async_req",   {31'b0, bus.o_Req},   32'd0);
        checkVal("async_valid", {31'b0, bus.o_Valid}, 32'd0);
        checkVal("async_addr",  bus.ov_Addr,          32'h0000_0100);
        checkVal("async_instr", bus.ov_Instr,         32'h0000_0013);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) applyStimulus(1, 1, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RISC-V core: owns the fetch PC, issues word reads to instruction memory (one outstanding request), buffers returned words with their PCs in a small FIFO, and presents them to decode, where the immediate generator (sign_ext) consumes the instruction word. Execute can redirect the fetch PC for branches and jumps; a redirect flushes buffered words and discards any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, FIFO entries (power of two, ≥2)
- i_Clk  in  1  clock, rising edge
- i_Rst  in  1  asynchronous, active-high reset
- i_Enb  in  1  global stall enable; 0 freezes every register
- o_Req  out  1  memory read request
- ov_Addr  out  32  memory word address, bits [1:0] always 0
- i_Ack  in  1  memory response valid this cycle
- iv_Rdata  in  32  instruction word, valid when i_Ack=1
- i_Redirect  in  1  load new fetch PC
- iv_Target  in  32  redirect address
- o_Valid  out  1  FIFO head valid
- ov_Instr  out  32  FIFO head instruction; 32'h0000_0013 when o_Valid=0
- ov_Pc  out  32  FIFO head PC; 0 when o_Valid=0
- i_Ready  in  1  decode accepts head this cycle

## Operation
- Reset (async): state IDLE, o_Req=0, ov_Addr=RESET_PC, FIFO count=0, o_Valid=0, ov_Instr=32'h0000_0013, ov_Pc=0.
- All transitions below occur only on edges with i_Enb=1; with i_Enb=0 all registers hold and i_Ack is ignored (memory shares the same enable).
- Memory protocol: o_Req and ov_Addr registered, held stable until an edge with i_Ack=1; iv_Rdata sampled on that edge. Ack may come in the first cycle o_Req is high.
- Room: a request may be issued/continued only if FIFO count after this edge's push/pop < DEPTH.
- States:
  - IDLE (o_Req=0): if room -> REQ, o_Req=1, ov_Addr unchanged.
  - REQ (o_Req=1): on ack -> push {ov_Addr, iv_Rdata}, ov_Addr+=4 (wraps 0xFFFF_FFFC -> 0); stay REQ if room else IDLE. No ack -> hold.
  - DRAIN (o_Req=1, stale address): on ack -> data discarded, ov_Addr<=pending target, -> REQ if room (always true, FIFO empty). No ack -> hold.
- Redirect (highest priority): FIFO flushed (count=0, no pop, no push this edge); target = {iv_Target[31:2],2'b00}.
  - State IDLE, or REQ with i_Ack=1 this edge: ov_Addr<=target, -> REQ, o_Req=1.
  - State REQ without ack, or DRAIN without ack: pending target<=target, -> DRAIN (later redirect overwrites pending).
  - DRAIN with ack: ov_Addr<=target, -> REQ.
- Pop: o_Valid & i_Ready & ~i_Redirect on an enabled edge. Push and pop on the same edge leave count unchanged; at count=DEPTH-1 this keeps o_Req=1.
- ov_Instr/ov_Pc/o_Valid are combinational from FIFO head register and count.

## Timing
- Reset release -> o_Req=1 after first enabled edge; ov_Addr=RESET_PC.
- Ack at edge k -> word visible at ov_Instr, o_Valid=1 from cycle after edge k.
- Continuous acks with i_Ready=1: one instruction per cycle, ov_Addr advances by 4 each cycle.
- Redirect at edge k with no outstanding request: ov_Addr=target, o_Req=1 after edge k; o_Valid=0 after edge k.
- Redirect with outstanding request: stale response consumed on its ack edge; target address issued the cycle after that ack.
- i_Ready=0 with DEPTH=2: after two acks o_Req drops (IDLE); pop edge restores o_Req=1 after that edge.

## Test plan
- Reset, RESET_PC=0x100, memory acks every cycle with data=addr^0xA5A5_0000, i_Ready=1 -> ov_Pc 0x100,0x104,0x108… consecutive cycles, ov_Instr matches, o_Req stays 1.
- i_Ready=0 -> exactly 2 words buffered (0x100,0x104), o_Req=0, ov_Addr=0x108; raise i_Ready -> words popped in order, fetching resumes at 0x108.
- Memory ack delayed 3 cycles, redirect to 0x203 on cycle 1 of wait -> ov_Addr held at old value until ack, response discarded (o_Valid stays 0), next request at 0x200, first output ov_Pc=0x200.
- Redirect on same edge as ack of 0x108 -> 0x108 word dropped, FIFO flushed, next ov_Addr=0x40 (target 0x40).
- i_Enb=0 for 5 cycles mid-stream with i_Ack=1 pulses -> no state change, outputs frozen; resume gives identical sequence to unstalled run.
- Fetch from RESET_PC=0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; assert i_Rst mid-request -> o_Req=0, o_Valid=0, ov_Addr=RESET_PC immediately.
